// File: rtl/prei_md_ram_ctrl.sv
// Single-port access controller for the 85x6 pre-intra mode RAM: arbitrates a mode writer and a
// mode reader, and runs a per-CTU clear sweep that loads the default mode into every entry.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | serve client requests (round-robin when both request)
//   ST_CLR  | sweep writes CLR_VAL to one entry per cycle, clients wait
module prei_md_ram_ctrl #(
  parameter int                ADR_WD  = 7,
  parameter int                DEPTH   = 85,
  parameter int                DAT_WD  = 6,
  parameter logic [DAT_WD-1:0] CLR_VAL = DAT_WD'(1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr_start_i,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  input  logic              wr_req_i,
  input  logic [ADR_WD-1:0] wr_adr_i,
  input  logic [DAT_WD-1:0] wr_dat_i,
  output logic              wr_ack_o,
  input  logic              rd_req_i,
  input  logic [ADR_WD-1:0] rd_adr_i,
  output logic              rd_ack_o,
  output logic              rd_vld_o,
  output logic [DAT_WD-1:0] rd_dat_o,
  output logic              err_adr_o,
  output logic [ADR_WD-1:0] ram_adr_o,
  output logic              ram_wr_ena_o,
  output logic [DAT_WD-1:0] ram_wr_dat_o,
  output logic              ram_rd_ena_o,
  input  logic [DAT_WD-1:0] ram_rd_dat_i
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CLR  = 1'b1;

  localparam logic [ADR_WD:0]   DEPTH_W  = (ADR_WD+1)'(DEPTH);
  localparam logic [ADR_WD-1:0] LAST_ADR = ADR_WD'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADR_WD-1:0] sweep_cnt;
  logic              clr_done_q;
  logic              rr_rd;
  logic              rd_vld_q;
  logic              rd_oor_q;
  logic              err_q;
  logic [DAT_WD-1:0] hold_q;

  logic serve;
  logic wr_oor;
  logic rd_oor;
  logic gnt_wr;
  logic gnt_rd;
  logic contended;

  // No grant in the cycle clr_start_i arrives, so the sweep owns the port from its first cycle.
  assign serve     = (state == ST_IDLE) && !clr_start_i;
  assign wr_oor    = {1'b0, wr_adr_i} >= DEPTH_W;
  assign rd_oor    = {1'b0, rd_adr_i} >= DEPTH_W;
  assign contended = serve && wr_req_i && rd_req_i;
  assign gnt_wr    = serve && wr_req_i && (!rd_req_i || !rr_rd);
  assign gnt_rd    = serve && rd_req_i && (!wr_req_i || rr_rd);

  assign wr_ack_o   = gnt_wr;
  assign rd_ack_o   = gnt_rd;
  assign clr_busy_o = (state == ST_CLR);
  assign clr_done_o = clr_done_q;
  assign err_adr_o  = err_q;
  assign rd_vld_o   = rd_vld_q;

  // An out-of-range read never touched the RAM, so it returns the cleared value instead.
  assign rd_dat_o = rd_vld_q ? (rd_oor_q ? CLR_VAL : ram_rd_dat_i) : hold_q;

  always_comb begin
    ram_adr_o    = '0;
    ram_wr_dat_o = '0;
    ram_wr_ena_o = 1'b1;
    ram_rd_ena_o = 1'b1;
    if (state == ST_CLR) begin
      ram_adr_o    = sweep_cnt;
      ram_wr_dat_o = CLR_VAL;
      ram_wr_ena_o = 1'b0;
    end else if (gnt_wr && !wr_oor) begin
      ram_adr_o    = wr_adr_i;
      ram_wr_dat_o = wr_dat_i;
      ram_wr_ena_o = 1'b0;
    end else if (gnt_rd && !rd_oor) begin
      ram_adr_o    = rd_adr_i;
      ram_rd_ena_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      sweep_cnt  <= '0;
      clr_done_q <= 1'b0;
      rr_rd      <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_oor_q   <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= '0;
    end else begin
      clr_done_q <= (state == ST_CLR) && (sweep_cnt == LAST_ADR);
      case (state)
        ST_IDLE: begin
          if (clr_start_i) begin
            state     <= ST_CLR;
            sweep_cnt <= '0;
          end
        end
        ST_CLR: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_ADR) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // The pointer names the next contended winner; only a contended grant moves it.
      if (contended) rr_rd <= ~rr_rd;

      rd_vld_q <= gnt_rd;
      rd_oor_q <= gnt_rd && rd_oor;
      if (rd_vld_q) hold_q <= rd_dat_o;

      if (clr_start_i) err_q <= 1'b0;
      else if ((gnt_wr && wr_oor) || (gnt_rd && rd_oor)) err_q <= 1'b1;
    end
  end

endmodule
